// File: rtl/prbs_pkg.sv
// prbs_pkg: shared constants and types for the PRBS checker slice.
//   - prbs_state_e : checker FSM encoding (hunt / verify / locked)
//   - Prbs7Taps    : PRBS7 feedback mask, next bit = s[6] ^ s[5]
//   - Def*         : default checker parameters
package prbs_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StVerify,
    StLocked
  } prbs_state_e;

  localparam int unsigned PrbsWidth     = 7;
  localparam logic [6:0]  Prbs7Taps     = 7'h60;
  localparam int unsigned DefLockCnt    = 16;
  localparam int unsigned DefLossWin    = 64;
  localparam int unsigned DefLossThresh = 8;
  localparam int unsigned DefErrCntW    = 16;

endpackage

// File: rtl/prbs_checker_if.sv
// prbs_checker_if: serial receive bundle for the PRBS checker.
//   din_valid, din, clear : stream source -> checker
//   locked, err_pulse     : checker status strobes
//   err_count             : saturating error total (ERR_CNT_W bits)
// master = stream source / observer, slave = checker.
interface prbs_checker_if
  import prbs_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = DefErrCntW
) ();

  logic                 din_valid;
  logic                 din;
  logic                 clear;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output din_valid,
    output din,
    output clear,
    input  locked,
    input  err_pulse,
    input  err_count
  );

  modport slave (
    input  din_valid,
    input  din,
    input  clear,
    output locked,
    output err_pulse,
    output err_count
  );

endinterface

// File: rtl/prbs_lfsr.sv
// prbs_lfsr: Fibonacci LFSR with a selectable shift-in source.
//   clk, rst_n : clock, async active-low reset (state clears to 0)
//   shift_en   : advance the register this cycle
//   sel_ext    : 1 = shift in ext_bit, 0 = shift in own prediction (free-run)
//   ext_bit    : external bit to shift in
//   pred       : predicted next bit, ^(state & TAPS)
//   state_next : value the register takes if shifted this cycle
// Shared with the generator block, so it carries no checker-specific logic.
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int unsigned      WIDTH = PrbsWidth,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(Prbs7Taps)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             sel_ext,
  input  logic             ext_bit,
  output logic             pred,
  output logic [WIDTH-1:0] state_next
);

  logic [WIDTH-1:0] state_q;
  logic             shift_in;

  assign pred       = ^(state_q & TAPS);
  assign shift_in   = sel_ext ? ext_bit : pred;
  assign state_next = {state_q[WIDTH-2:0], shift_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else if (shift_en) begin
      state_q <= state_next;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising serial PRBS checker.
//   clk, rst_n : clock, async active-low reset
//   bus        : prbs_checker_if.slave
//                in : din_valid, din, clear
//                out: locked, err_pulse, err_count (all registered)
// Hunt fills the LFSR from the stream, verify requires LOCK_CNT consecutive
// correct predictions, locked free-runs the LFSR and counts errors; too many
// errors inside one LOSS_WIN window drops back to hunt.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned      WIDTH       = PrbsWidth,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(Prbs7Taps),
  parameter int unsigned      LOCK_CNT    = DefLockCnt,
  parameter int unsigned      LOSS_WIN    = DefLossWin,
  parameter int unsigned      LOSS_THRESH = DefLossThresh,
  parameter int unsigned      ERR_CNT_W   = DefErrCntW
) (
  input logic            clk,
  input logic            rst_n,
  prbs_checker_if.slave  bus
);

  localparam int unsigned FillW  = $clog2(WIDTH + 1);
  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WinW   = $clog2(LOSS_WIN + 1);
  localparam int unsigned ThrW   = $clog2(LOSS_THRESH + 1);

  prbs_state_e          state_q, state_d;
  logic [FillW-1:0]     fill_q, fill_d;
  logic [MatchW-1:0]    match_q, match_d;
  logic [WinW-1:0]      wbit_q, wbit_d;
  logic [ThrW-1:0]      werr_q, werr_d;
  logic                 locked_q, locked_d;
  logic                 pulse_q, pulse_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic             shift_en;
  logic             sel_ext;
  logic             pred;
  logic             mismatch;
  logic             win_last;
  logic [WIDTH-1:0] state_next;

  prbs_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (shift_en),
    .sel_ext    (sel_ext),
    .ext_bit    (bus.din),
    .pred       (pred),
    .state_next (state_next)
  );

  assign mismatch = bus.din ^ pred;
  assign win_last = (wbit_q == WinW'(LOSS_WIN - 1));

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    match_d  = match_q;
    wbit_d   = wbit_q;
    werr_d   = werr_q;
    locked_d = locked_q;
    pulse_d  = 1'b0;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    sel_ext  = 1'b1;

    if (bus.din_valid) begin
      shift_en = 1'b1;
      unique case (state_q)
        StHunt: begin
          if (fill_q == FillW'(WIDTH - 1)) begin
            fill_d = '0;
            // An all-zero seed would lock up the LFSR: refill instead.
            if (state_next != '0) begin
              state_d = StVerify;
              match_d = '0;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        StVerify: begin
          if (mismatch) begin
            state_d = StHunt;
            fill_d  = '0;
          end else if (match_q == MatchW'(LOCK_CNT - 1)) begin
            state_d  = StLocked;
            locked_d = 1'b1;
            wbit_d   = '0;
            werr_d   = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        StLocked: begin
          // Free-run so a corrupted input bit cannot poison later predictions.
          sel_ext = 1'b0;
          if (win_last) begin
            wbit_d = '0;
            werr_d = '0;
          end else begin
            wbit_d = wbit_q + 1'b1;
          end
          if (mismatch) begin
            pulse_d = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
            // The error on a window's last bit still counts toward that window.
            if (werr_q == ThrW'(LOSS_THRESH - 1)) begin
              state_d  = StHunt;
              locked_d = 1'b0;
              fill_d   = '0;
            end else if (!win_last) begin
              werr_d = werr_q + 1'b1;
            end
          end
        end
        default: begin
          state_d  = StHunt;
          locked_d = 1'b0;
          fill_d   = '0;
        end
      endcase
    end

    // Clear wins over a same-cycle error increment.
    if (bus.clear) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StHunt;
      fill_q   <= '0;
      match_q  <= '0;
      wbit_q   <= '0;
      werr_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      wbit_q   <= wbit_d;
      werr_q   <= werr_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = pulse_q;
  assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: scoreboard bench for prbs_checker. Two checkers share one
// stimulus stream: a default 16-bit error counter and a 4-bit one for
// saturation. A behavioural reference model produces the expected outputs,
// which are queued when a bit is driven and compared after the clock edge.
module tb_prbs_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  prbs_checker_if #(.ERR_CNT_W(16)) bus16 ();
  prbs_checker_if #(.ERR_CNT_W(4))  bus4 ();

  assign bus4.din_valid = bus16.din_valid;
  assign bus4.din       = bus16.din;
  assign bus4.clear     = bus16.clear;

  prbs_checker #(.ERR_CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  prbs_checker #(.ERR_CNT_W(4)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  typedef struct packed {
    logic        locked;
    logic        pulse;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference model state
  int         m_st;     // 0 hunt, 1 verify, 2 locked
  logic [6:0] m_s;
  int         m_fill, m_match, m_wbit, m_werr;
  logic       m_locked, m_pulse;
  int         m_c16, m_c4;

  logic [6:0] g;        // stimulus generator state

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_s = '0; m_fill = 0; m_match = 0; m_wbit = 0; m_werr = 0;
    m_locked = 1'b0; m_pulse = 1'b0; m_c16 = 0; m_c4 = 0;
  endtask

  task automatic model_step(input logic v, input logic d, input logic c);
    logic b;
    m_pulse = 1'b0;
    if (v) begin
      b = m_s[6] ^ m_s[5];
      if (m_st == 0) begin
        m_s = {m_s[5:0], d};
        m_fill++;
        if (m_fill == 7) begin
          m_fill = 0;
          if (m_s != 7'd0) begin
            m_st = 1;
            m_match = 0;
          end
        end
      end else if (m_st == 1) begin
        m_s = {m_s[5:0], d};
        if (d == b) begin
          m_match++;
          if (m_match == 16) begin
            m_st = 2; m_locked = 1'b1; m_wbit = 0; m_werr = 0;
          end
        end else begin
          m_st = 0; m_fill = 0;
        end
      end else begin
        m_s = {m_s[5:0], b};
        if (d != b) begin
          m_pulse = 1'b1;
          if (m_c16 < 65535) m_c16++;
          if (m_c4 < 15) m_c4++;
          m_werr++;
        end
        m_wbit++;
        if (m_werr == 8) begin
          m_st = 0; m_fill = 0; m_locked = 1'b0;
        end else if (m_wbit == 64) begin
          m_wbit = 0; m_werr = 0;
        end
      end
    end
    if (c) begin
      m_c16 = 0;
      m_c4 = 0;
    end
  endtask

  task automatic gen_bit(output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  task automatic drive_bit(input logic v, input logic d, input logic c);
    exp_t e;
    bus16.din_valid = v;
    bus16.din       = d;
    bus16.clear     = c;
    model_step(v, d, c);
    e.locked = m_locked;
    e.pulse  = m_pulse;
    e.cnt16  = 16'(m_c16);
    e.cnt4   = 4'(m_c4);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("locked", 32'(bus16.locked), 32'(e.locked));
    check_val("err_pulse", 32'(bus16.err_pulse), 32'(e.pulse));
    check_val("err_count", 32'(bus16.err_count), 32'(e.cnt16));
    check_val("sat_locked", 32'(bus4.locked), 32'(e.locked));
    check_val("sat_err_count", 32'(bus4.err_count), 32'(e.cnt4));
  endtask

  task automatic reset_all();
    bus16.din_valid = 1'b0;
    bus16.din       = 1'b0;
    bus16.clear     = 1'b0;
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_locked", 32'(bus16.locked), 0);
    check_val("rst_err_pulse", 32'(bus16.err_pulse), 0);
    check_val("rst_err_count", 32'(bus16.err_count), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic b;
    int   lock_at, pulses, guard;
    bit   ever_locked;

    // Clean stream, one inverted bit after lock
    reset_all();
    g = 7'h01; lock_at = 0; pulses = 0;
    for (int i = 1; i <= 500; i++) begin
      gen_bit(b);
      drive_bit(1'b1, (i == 100) ? ~b : b, 1'b0);
      if (lock_at == 0 && bus16.locked) lock_at = i;
      if (bus16.err_pulse) pulses++;
      if (i == 99) check_val("clean_count", 32'(bus16.err_count), 0);
    end
    check_val("lock_latency", lock_at, 23);
    check_val("single_err_pulses", pulses, 1);
    check_val("single_err_count", 32'(bus16.err_count), 1);
    check_val("single_err_locked", 32'(bus16.locked), 1);

    // Clear, then 8 errors inside one window drop lock
    gen_bit(b);
    drive_bit(1'b1, b, 1'b1);
    check_val("clear_count", 32'(bus16.err_count), 0);
    guard = 0;
    while (m_wbit != 0 && guard < 70) begin
      gen_bit(b);
      drive_bit(1'b1, b, 1'b0);
      guard++;
    end
    check_val("window_align", m_wbit, 0);
    for (int k = 0; k <= 14; k++) begin
      gen_bit(b);
      drive_bit(1'b1, (k % 2 == 0) ? ~b : b, 1'b0);
      if (k == 12) check_val("hold_after_7th", 32'(bus16.locked), 1);
    end
    check_val("loss_on_8th", 32'(bus16.locked), 0);
    lock_at = 0;
    for (int j = 1; j <= 40; j++) begin
      gen_bit(b);
      drive_bit(1'b1, b, 1'b0);
      if (lock_at == 0 && bus16.locked) lock_at = j;
    end
    check_val("relock_latency", lock_at, 23);
    check_val("count_after_loss", 32'(bus16.err_count), 8);

    // din_valid every other cycle, then error with simultaneous clear
    reset_all();
    g = 7'h01; lock_at = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c % 2 == 0) begin
        gen_bit(b);
        drive_bit(1'b1, b, 1'b0);
      end else begin
        drive_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      if (lock_at == 0 && bus16.locked) lock_at = c;
    end
    check_val("gapped_lock_clocks", lock_at, 46);
    gen_bit(b);
    drive_bit(1'b1, ~b, 1'b1);
    check_val("clear_err_pulse", 32'(bus16.err_pulse), 1);
    check_val("clear_err_count", 32'(bus16.err_count), 0);
    drive_bit(1'b0, 1'b0, 1'b0);
    check_val("pulse_drop_idle", 32'(bus16.err_pulse), 0);

    // All-zero stream never locks
    reset_all();
    ever_locked = 1'b0;
    for (int i = 0; i < 200; i++) begin
      drive_bit(1'b1, 1'b0, 1'b0);
      if (bus16.locked) ever_locked = 1'b1;
    end
    check_val("zeros_never_lock", 32'(ever_locked), 0);
    check_val("zeros_count", 32'(bus16.err_count), 0);

    // 7 errors per window over 3 windows: lock held, 4-bit count saturates
    reset_all();
    g = 7'h01;
    for (int i = 0; i < 23; i++) begin
      gen_bit(b);
      drive_bit(1'b1, b, 1'b0);
    end
    check_val("sat_lock", 32'(bus16.locked), 1);
    for (int i = 0; i < 3 * 64; i++) begin
      logic inv;
      inv = (m_wbit < 14) && (m_wbit % 2 == 0);
      gen_bit(b);
      drive_bit(1'b1, inv ? ~b : b, 1'b0);
    end
    check_val("sat_hold_lock", 32'(bus16.locked), 1);
    check_val("sat_wide_count", 32'(bus16.err_count), 21);
    check_val("sat_narrow_count", 32'(bus4.err_count), 15);
    for (int i = 0; i < 10; i++) begin
      logic inv;
      inv = (i % 3 == 0);
      gen_bit(b);
      drive_bit(1'b1, inv ? ~b : b, 1'b0);
    end

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_locked", 32'(bus16.locked), 0);
    check_val("async_err_pulse", 32'(bus16.err_pulse), 0);
    check_val("async_err_count", 32'(bus16.err_count), 0);
    check_val("async_sat_count", 32'(bus4.err_count), 0);
    check_val("async_sat_locked", 32'(bus4.locked), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
